// File: rtl/addf_seq_pkg.sv
// Shared types and defaults for the multi-word add sequencer and its word adder.
package addf_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ       = 2;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_NWORDS = 4;

    typedef logic id_t;

endpackage

// File: rtl/CC_ADDF.sv
// Behavioural model of the GateMate CC_ADDF full-adder cell, used where the
// vendor cell library is not present.
module CC_ADDF (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic CO,
    output logic S
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/addf_word.sv
// WORD_W-bit combinational ripple-carry adder built as a chain of CC_ADDF cells.
module addf_word
    import addf_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              ci,
    output logic [WORD_W-1:0] s,
    output logic              co
);

    logic [WORD_W:0] carry;

    assign carry[0] = ci;
    assign co       = carry[WORD_W];

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_cell
            CC_ADDF u_addf (
                .A  (a[gi]),
                .B  (b[gi]),
                .CI (carry[gi]),
                .CO (carry[gi+1]),
                .S  (s[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/addf_seq_arbiter.sv
// Two-requester round-robin front end that runs NWORDS*WORD_W-bit additions
// one word per cycle through a single shared addf_word. Define ADDF_SEQ_SUB_EN
// to add per-requester subtract inputs.
module addf_seq_arbiter
    import addf_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int NWORDS = DEF_NWORDS,
    localparam int OPW   = WORD_W * NWORDS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    input  logic           req0_ci,
`ifdef ADDF_SEQ_SUB_EN
    input  logic           req0_sub,
    input  logic           req1_sub,
`endif
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    input  logic           req1_ci,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [OPW-1:0] rsp_s,
    output logic           rsp_co,
    output logic           busy
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t            state_reg;
    logic [OPW-1:0]    a_reg;
    logic [OPW-1:0]    b_reg;
    id_t               id_reg;
    id_t               last_reg;
    logic              carry_reg;
    logic              sub_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              rsp_valid_reg;
    logic              rsp_co_reg;
    logic [WORD_W-1:0] s_words_reg [NWORDS];

    logic [NREQ-1:0]   req_valid;
    id_t               grant_id;
    logic              grant_any;
    logic              accept;
    logic [OPW-1:0]    sel_a;
    logic [OPW-1:0]    sel_b;
    logic              sel_ci;
    logic              sel_sub;

    logic [WORD_W-1:0] a_words [NWORDS];
    logic [WORD_W-1:0] b_words [NWORDS];
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] sum_word;
    logic              sum_co;

    // Round-robin: on a conflict the requester not served last wins.
    assign req_valid = {req1_valid, req0_valid};
    assign grant_any = |req_valid;

    always_comb begin
        grant_id = 1'b0;
        if (&req_valid) begin
            grant_id = ~last_reg;
        end else begin
            grant_id = req_valid[1];
        end
    end

    assign accept     = rst_n && (state_reg == IDLE) && grant_any;
    assign req0_ready = accept && (grant_id == 1'b0);
    assign req1_ready = accept && (grant_id == 1'b1);

    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;
    assign sel_ci = grant_id ? req1_ci : req0_ci;
`ifdef ADDF_SEQ_SUB_EN
    assign sel_sub = grant_id ? req1_sub : req0_sub;
`else
    assign sel_sub = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
            assign a_words[gi] = a_reg[gi*WORD_W +: WORD_W];
            assign b_words[gi] = b_reg[gi*WORD_W +: WORD_W];
            assign rsp_s[gi*WORD_W +: WORD_W] = s_words_reg[gi];
        end
    endgenerate

    // Subtraction is A + ~B + ~ci, so only B and the initial carry change.
    assign add_b = b_words[idx_reg] ^ {WORD_W{sub_reg}};

    addf_word #(.WORD_W(WORD_W)) u_word (
        .a  (a_words[idx_reg]),
        .b  (add_b),
        .ci (carry_reg),
        .s  (sum_word),
        .co (sum_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= 1'b0;
            last_reg      <= 1'b1;
            carry_reg     <= 1'b0;
            sub_reg       <= 1'b0;
            idx_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_co_reg    <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                s_words_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        id_reg    <= grant_id;
                        last_reg  <= grant_id;
                        sub_reg   <= sel_sub;
                        carry_reg <= sel_ci ^ sel_sub;
                        idx_reg   <= '0;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    s_words_reg[idx_reg] <= sum_word;
                    carry_reg            <= sum_co;
                    if (idx_reg == LAST_IDX) begin
                        rsp_co_reg    <= sum_co;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = id_reg;
    assign rsp_co    = rsp_co_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_addf_seq_arbiter.sv
// Self-checking bench for addf_seq_arbiter: a cycle-level reference model plus
// directed operations with literal expected sums (subtract cases under ADDF_SEQ_SUB_EN).
module tb_addf_seq_arbiter;

    localparam int WORD_W = 16;
    localparam int NWORDS = 4;
    localparam int OPW    = WORD_W * NWORDS;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [OPW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic           req0_ci, req1_ci;
    logic           req0_sub, req1_sub;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_co, busy;
    logic [OPW-1:0] rsp_s;

    int checks   = 0;
    int failures = 0;

    bit grants_q[$];

    addf_seq_arbiter #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ci    (req0_ci),
`ifdef ADDF_SEQ_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ci    (req1_ci),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_co     (rsp_co),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full-width arithmetic result: {carry/no-borrow, sum}.
    function automatic logic [OPW:0] model_result(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                                  input logic ci, input logic sub);
        logic [OPW:0] r;
        if (sub) begin
            r = {1'b0, a} - {1'b0, b} - {{OPW{1'b0}}, ci};
            r[OPW] = ~r[OPW];
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, ci};
        end
        return r;
    endfunction

    // Reference model: 0 = idle, 1 = adding (m_left cycles to go), 2 = result held.
    int           m_state = 0;
    int           m_left  = 0;
    bit           m_last  = 1'b1;
    bit           m_id    = 1'b0;
    logic [OPW:0] m_res   = '0;

    always @(negedge clk) begin
        bit g;
        bit any;
        if (!rst_n) begin
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_s", rsp_s, 0);
            check("rst_rsp_co", rsp_co, 0);
            m_state = 0;
            m_last  = 1'b1;
        end else begin
            any = req0_valid || req1_valid;
            g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            check("req0_ready", req0_ready, (m_state == 0) && any && !g);
            check("req1_ready", req1_ready, (m_state == 0) && any && g);
            check("busy", busy, m_state != 0);
            check("rsp_valid", rsp_valid, m_state == 2);
            if (m_state == 2) begin
                check("rsp_s", rsp_s, m_res[OPW-1:0]);
                check("rsp_co", rsp_co, m_res[OPW]);
                check("rsp_id", rsp_id, m_id);
            end
            if (req0_ready && req0_valid) grants_q.push_back(1'b0);
            if (req1_ready && req1_valid) grants_q.push_back(1'b1);
            case (m_state)
                0: if (any) begin
                    m_id    = g;
                    m_last  = g;
                    m_res   = g ? model_result(req1_a, req1_b, req1_ci, req1_sub)
                                : model_result(req0_a, req0_b, req0_ci, req0_sub);
                    m_left  = NWORDS;
                    m_state = 1;
                    $display("ACCEPT id=%0d a=0x%0h b=0x%0h ci=%0d sub=%0d", g,
                             g ? req1_a : req0_a, g ? req1_b : req0_b,
                             g ? req1_ci : req0_ci, g ? req1_sub : req0_sub);
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                default: if (rsp_ready) begin
                    $display("RESULT id=%0d s=0x%0h co=%0d", rsp_id, rsp_s, rsp_co);
                    m_state = 0;
                end
            endcase
        end
    end

    task automatic do_op(input bit who, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic ci, input logic sub, input logic [OPW-1:0] exp_s,
                         input logic exp_co, input string name);
        int  n;
        bit  got;
        @(posedge clk); #1;
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ci = ci; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ci = ci; req0_sub = sub;
        end
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            got = who ? req1_ready : req0_ready;
            n++;
        end
        check({name, "_accept"}, got, 1);
        @(posedge clk); #1;
        // Scramble the inputs to show the operation uses latched operands.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        req0_ci = ~ci; req1_ci = ~ci; req0_sub = ~sub; req1_sub = ~sub;
        n = 0; got = 0;
        while (n < 20) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            n++;
        end
        check({name, "_latency"}, n, NWORDS);
        check({name, "_s"}, rsp_s, exp_s);
        check({name, "_co"}, rsp_co, exp_co);
        check({name, "_id"}, rsp_id, who);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [OPW-1:0] ones;
        ones = '1;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ci = 1'b0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_ci = 1'b0; req1_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready_gated", req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b1;

        do_op(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
              64'h0000_0000_0001_0000, 1'b0, "t1_word_carry");
        do_op(1'b1, ones, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, "t2_full_carry");

        // Round-robin with both requesters always pending, from reset.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grants_q.delete();
        req0_valid = 1'b1; req0_a = 64'd10;  req0_b = 64'd20; req0_ci = 1'b0; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd100; req1_b = 64'd1;  req1_ci = 1'b1; req1_sub = 1'b0;
        n = 0;
        while (n < 60 && grants_q.size() < 4) begin
            @(posedge clk); #1;
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_grant_count", grants_q.size(), 4);
        repeat (8) @(posedge clk);
        if (grants_q.size() >= 4) begin
            check("rr_grant0", grants_q[0], 0);
            check("rr_grant1", grants_q[1], 1);
            check("rr_grant2", grants_q[2], 0);
            check("rr_grant3", grants_q[3], 1);
        end

        // Back-pressure in DONE with the other requester waiting.
        rsp_ready = 1'b0;
        do_op(1'b0, 64'h1234, 64'h1111, 1'b0, 1'b0, 64'h2345, 1'b0, "t4_hold");
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 64'd3; req1_b = 64'd4; req1_ci = 1'b0; req1_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_s", rsp_s, 64'h2345);
            check("hold_busy", busy, 1);
            check("hold_ready0", req0_ready, 0);
            check("hold_ready1", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_busy", busy, 0);
        check("release_valid", rsp_valid, 0);
        check("release_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (8) @(posedge clk);

        // Abort mid-ADD, then confirm no stale carry survives.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = ones; req0_b = ones; req0_ci = 1'b1; req0_sub = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req0_ready) break;
            n++;
        end
        check("abort_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(1'b0, 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, "t5_after_abort");

`ifdef ADDF_SEQ_SUB_EN
        do_op(1'b0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "t6_sub_borrow");
        do_op(1'b1, 64'd7, 64'd5, 1'b0, 1'b1, 64'h2, 1'b1, "t6_sub_noborrow");
`endif

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
